// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the FFT datapath multiplier and divider.
// Words are sign-magnitude: {sign, integer bits, FRAC fraction bits}.
package fixed_point_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    typedef logic [WIDTH-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift the next numerator bit into the remainder,
// subtract the divisor when it fits and emit the matching quotient bit.
module fixed_point_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-2:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dsr_ext;

    assign shifted = {rem, next_bit};
    assign dsr_ext = {2'b00, divisor};
    assign q_bit   = (shifted >= dsr_ext);

    // The remainder never reaches the divisor, so the carry-out bit is always zero.
    assign rem_next = WIDTH'(q_bit ? shifted - dsr_ext : shifted);

endmodule

// File: rtl/fixed_point_divide.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per cycle.
// Saturates on overflow and on divide by zero; one division in flight.
module fixed_point_divide #(
    parameter int WIDTH = fixed_point_pkg::WIDTH,
    parameter int FRAC  = fixed_point_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero
);

    import fixed_point_pkg::*;

    localparam int MAG_W = WIDTH - 1;
    localparam int N     = WIDTH - 1 + FRAC;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    div_state_t       state, state_nxt;
    logic [N-1:0]     num_sr;
    logic [N-2:0]     quo_sr;
    logic [WIDTH-1:0] rem;
    logic [MAG_W-1:0] dsr_mag;
    logic             sign;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             zero_div;
    logic             in_sign;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;
    logic [N-1:0]     quo_full;
    logic             ovf_res;
    logic [MAG_W-1:0] res_mag;
    logic [WIDTH-1:0] result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign zero_div  = (divisor[MAG_W-1:0] == '0);
    assign in_sign   = dividend[WIDTH-1] ^ divisor[WIDTH-1];

    fixed_point_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .divisor  (dsr_mag),
        .next_bit (num_sr[N-1]),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    assign quo_full = {quo_sr, q_bit};

    // Final result formatting, only captured on the last iteration.
    always_comb begin
        ovf_res = |quo_full[N-1:MAG_W];
        res_mag = ovf_res ? {MAG_W{1'b1}} : quo_full[MAG_W-1:0];
        result  = {sign && (res_mag != '0), res_mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = zero_div ? DONE : BUSY;
            BUSY:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_sr      <= '0;
            quo_sr      <= '0;
            rem         <= '0;
            dsr_mag     <= '0;
            sign        <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    sign    <= in_sign;
                    num_sr  <= {dividend[MAG_W-1:0], {FRAC{1'b0}}};
                    dsr_mag <= divisor[MAG_W-1:0];
                    rem     <= '0;
                    quo_sr  <= '0;
                    cnt     <= '0;
                    if (zero_div) begin
                        quotient    <= {in_sign, {MAG_W{1'b1}}};
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end
                end
                BUSY: begin
                    rem    <= rem_nxt;
                    quo_sr <= quo_full[N-2:0];
                    num_sr <= {num_sr[N-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient <= result;
                        overflow <= ovf_res;
                    end
                end
                DONE: if (out_ready) begin
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divide.sv
// Directed and randomized checks of fixed_point_divide against an arithmetic reference.
module tb_fixed_point_divide;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic        overflow;
    logic        div_by_zero;

    int n_chk = 0;
    int n_fail = 0;

    fixed_point_divide dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude quotient in LSBs of 2^-8, truncated, then saturated.
    task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic ovf, output logic dbz);
        int unsigned am, bm, full;
        logic        s;
        logic [14:0] mag;
        am = a[14:0];
        bm = b[14:0];
        s  = a[15] ^ b[15];
        ovf = 1'b0;
        dbz = 1'b0;
        if (bm == 0) begin
            dbz = 1'b1;
            mag = 15'h7FFF;
        end else begin
            full = (am * 256) / bm;
            if (full > 32767) begin
                ovf = 1'b1;
                mag = 15'h7FFF;
            end else begin
                mag = full[14:0];
            end
        end
        if (mag == 0) s = 1'b0;
        q = {s, mag};
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check("in_ready_before_op", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq;
        logic        eo, ed;
        ref_div(a, b, eq, eo, ed);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_overflow"}, overflow, eo);
        check({tag, "_div_by_zero"}, div_by_zero, ed);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_flags", {overflow, div_by_zero}, 0);
    endtask

    task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int exp_lat);
        int lat;
        start_op(a, b);
        wait_done(lat);
        if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
        check_result(tag, a, b);
        take();
    endtask

    initial begin
        int          lat;
        logic [15:0] a, b;

        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_flags", {overflow, div_by_zero}, 0);
        @(negedge clk);
        rst = 1'b0;

        full_op("three_by_1p5", 16'h0300, 16'h0180, 24);
        check("three_by_1p5_const", quotient, 16'h0200);
        full_op("neg1_by_half", 16'h8100, 16'h0080, 24);
        check("neg1_by_half_const", quotient, 16'h8200);
        full_op("one_third", 16'h0100, 16'h0300, 24);
        full_op("sat_ovf", 16'h7F00, 16'h0001, 24);
        full_op("neg_zero_res", 16'h8000, 16'h0100, 24);
        full_op("div_neg_zero", 16'h0100, 16'h8000, 1);
        full_op("div_pos_zero", 16'h8123, 16'h0000, 1);
        full_op("max_by_max", 16'hFFFF, 16'h7FFF, 24);
        full_op("min_lsb", 16'h0001, 16'h8100, 24);

        // Result held while the consumer stalls; new operands ignored.
        start_op(16'h0300, 16'h0180);
        wait_done(lat);
        check("stall_latency", lat, 24);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'h1234;
            divisor  = 16'h0100;
            @(negedge clk);
            check("stall_quotient", quotient, 16'h0200);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_flags", {overflow, div_by_zero}, 0);
        end
        in_valid = 1'b0;
        take();
        check("stall_no_accept", in_ready, 1);

        // Back-to-back with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom);
            b = (i % 3 == 0) ? 16'($urandom_range(0, 3)) | (16'($urandom) & 16'h8000)
                             : 16'($urandom);
            start_op(a, b);
            wait_done(lat);
            check_result("b2b", a, b);
        end
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of an iteration run.
        start_op(16'h0500, 16'h0100);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_quotient", quotient, 0);
        #1;
        rst = 1'b0;
        full_op("after_rst", 16'h0500, 16'h0100, 24);

        // Randomized operands, mixing small and large divisors.
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            case (i % 4)
                0:       b = 16'($urandom_range(1, 255)) | (16'($urandom) & 16'h8000);
                1:       b = 16'($urandom_range(0, 16'hFFFF)) | 16'h4000;
                default: b = 16'($urandom);
            endcase
            full_op("rand", a, b, (b[14:0] == 0) ? 1 : 24);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
